// File: rtl/operand_fetch.sv
// operand_fetch -- issue stage between decode and execute.
//
// Reads the integer register file, bypasses same-cycle writeback data, tracks
// in-flight destination registers in a busy scoreboard, stalls on RAW/WAW
// hazards and hands the instruction to execute through one output register
// with a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill held instruction, block issue this cycle
//   id_*                     instruction offered by decode (valid/ready)
//   rf_rs1, rf_rs2           register file read indices
//   rf_rs1_data, rf_rs2_data combinational register file read data
//   wb_valid, wb_rd, wb_data writeback (same strobe as register file write)
//   ex_*                     output register to execute (valid/ready)

// Checker: a writeback must always retire a register some instruction owns.
module operand_fetch_chk (
   input logic        clk,
   input logic        rst,
   input logic        wb_valid,
   input logic [4:0]  wb_rd,
   input logic [31:0] busy
);
   // x0 writebacks are discarded by the register file and never tracked
   wb_owned_a: assert property (@(posedge clk) disable iff (rst)
      (wb_valid && wb_rd != 5'd0) |-> busy[wb_rd]);

   x0_never_busy_a: assert property (@(posedge clk) disable iff (rst)
      busy[0] == 1'b0);
endmodule

module operand_fetch #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [4:0]        id_rd,
   input  logic              id_rd_we,
   input  logic [CTRL_W-1:0] id_ctrl,
   output logic [4:0]        rf_rs1,
   output logic [4:0]        rf_rs2,
   input  logic [XLEN-1:0]   rf_rs1_data,
   input  logic [XLEN-1:0]   rf_rs2_data,
   input  logic              wb_valid,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_rs1_data,
   output logic [XLEN-1:0]   ex_rs2_data,
   output logic [4:0]        ex_rd,
   output logic              ex_rd_we,
   output logic [CTRL_W-1:0] ex_ctrl
);

   function automatic logic [31:0] onehot(input logic [4:0] idx);
      return 32'd1 << idx;
   endfunction

   // Writeback bypass: the register file write lands at the same edge we
   // capture, so its read data is stale for the index being written.
   function automatic logic [XLEN-1:0] bypass(
      input logic [4:0]      src,
      input logic [XLEN-1:0] rf_data,
      input logic            wbv,
      input logic [4:0]      wbr,
      input logic [XLEN-1:0] wbd
   );
      return (wbv && wbr == src && src != 5'd0) ? wbd : rf_data;
   endfunction

   logic [31:0]     busy_r;
   logic [31:0]     wb_clr_s;
   logic [31:0]     flush_clr_s;
   logic [31:0]     set_s;
   logic [31:0]     busy_eff_s;
   logic [31:0]     busy_next_s;
   logic            hazard_s;
   logic            issue_s;
   logic [XLEN-1:0] op1_s;
   logic [XLEN-1:0] op2_s;

   assign rf_rs1 = id_rs1;
   assign rf_rs2 = id_rs2;

   // Hazard detection, handshake and scoreboard next-state
   always_comb begin
      wb_clr_s    = wb_valid ? onehot(wb_rd) : 32'd0;
      // a register retiring this cycle is already free for the next reader
      busy_eff_s  = busy_r & ~wb_clr_s;
      hazard_s    = (id_rs1_used & busy_eff_s[id_rs1])
                  | (id_rs2_used & busy_eff_s[id_rs2])
                  | (id_rd_we & (id_rd != 5'd0) & busy_eff_s[id_rd]);
      id_ready    = ~flush & ~hazard_s & (~ex_valid | ex_ready);
      issue_s     = id_valid & id_ready;
      flush_clr_s = (flush & ex_valid & ex_rd_we) ? onehot(ex_rd) : 32'd0;
      set_s       = (issue_s & id_rd_we & (id_rd != 5'd0)) ? onehot(id_rd) : 32'd0;
      // set is applied last so a new owner wins over the old owner's retire
      busy_next_s = ((busy_r & ~flush_clr_s & ~wb_clr_s) | set_s) & ~32'd1;
      op1_s       = bypass(id_rs1, rf_rs1_data, wb_valid, wb_rd, wb_data);
      op2_s       = bypass(id_rs2, rf_rs2_data, wb_valid, wb_rd, wb_data);
   end

   // Output register to execute and busy scoreboard
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r      <= 32'd0;
         ex_valid    <= 1'b0;
         ex_rs1_data <= {XLEN{1'b0}};
         ex_rs2_data <= {XLEN{1'b0}};
         ex_rd       <= 5'd0;
         ex_rd_we    <= 1'b0;
         ex_ctrl     <= {CTRL_W{1'b0}};
      end else begin
         busy_r <= busy_next_s;
         if (issue_s) begin
            ex_valid    <= 1'b1;
            ex_rs1_data <= op1_s;
            ex_rs2_data <= op2_s;
            ex_rd       <= id_rd;
            ex_rd_we    <= id_rd_we;
            ex_ctrl     <= id_ctrl;
         end else if (flush || (ex_valid && ex_ready)) begin
            ex_valid <= 1'b0;
         end else begin
            ex_valid <= ex_valid;
         end
      end
   end

   operand_fetch_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .busy     (busy_r)
   );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed testbench for operand_fetch: a table of single-issue vectors from a
// clean scoreboard, then hand-written multi-cycle sequences for bypass,
// hazards, backpressure, flush, x0 and reset during a handshake.
module tb_operand_fetch;
   localparam int XLEN   = 64;
   localparam int CTRL_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              id_valid;
   logic              id_ready;
   logic [4:0]        id_rs1, id_rs2, id_rd;
   logic              id_rs1_used, id_rs2_used, id_rd_we;
   logic [CTRL_W-1:0] id_ctrl;
   logic [4:0]        rf_rs1, rf_rs2;
   logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              ex_valid, ex_ready;
   logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data;
   logic [4:0]        ex_rd;
   logic              ex_rd_we;
   logic [CTRL_W-1:0] ex_ctrl;

   int checks = 0;
   int errors = 0;

   operand_fetch #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_rd_we(id_rd_we), .id_ctrl(id_ctrl),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_ctrl(ex_ctrl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2, we;
      logic [63:0] rf1, rf2;
      logic [31:0] ctrl;
      logic [63:0] exp1, exp2;
      logic [31:0] exp_busy;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; id_valid = 1'b0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
      id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_we = 1'b0;
      id_ctrl = 32'd0; rf_rs1_data = 64'd0; rf_rs2_data = 64'd0;
      wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 64'd0; ex_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic op(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we,
                     input logic [63:0] d1, input logic [63:0] d2);
      id_valid = 1'b1;
      id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
      id_rd = rd; id_rd_we = we; rf_rs1_data = d1; rf_rs2_data = d2;
   endtask

   initial begin
      vecs[0] = '{5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 64'h11, 64'h22, 32'hC0DE0001,
                  64'h11, 64'h22, 32'h0000_0008};
      vecs[1] = '{5'd31, 5'd30, 5'd31, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0001, 32'h1, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0001, 32'h8000_0000};
      vecs[2] = '{5'd6, 5'd7, 5'd4, 1'b1, 1'b0, 1'b0, 64'h1234, 64'h5678, 32'hA5A5A5A5,
                  64'h1234, 64'h5678, 32'h0};
      vecs[3] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 64'h0, 64'h0, 32'h0,
                  64'h0, 64'h0, 32'h0};
      vecs[4] = '{5'd9, 5'd10, 5'd17, 1'b0, 1'b0, 1'b1, 64'hCAFE, 64'hBEEF, 32'h7,
                  64'hCAFE, 64'hBEEF, 32'h0002_0000};

      // reset state
      rst = 1'b1; idle();
      step(); step();
      chk("rst_ex_valid", ex_valid, 64'd0);
      chk("rst_ex_rs1", ex_rs1_data, 64'd0);
      chk("rst_ex_rd", ex_rd, 64'd0);
      chk("rst_ex_ctrl", ex_ctrl, 64'd0);
      chk("rst_busy", dut.busy_r, 64'd0);
      rst = 1'b0;

      // table: single issue from a clean scoreboard
      for (int i = 0; i < 5; i++) begin
         do_reset();
         op(vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, vecs[i].rd, vecs[i].we,
            vecs[i].rf1, vecs[i].rf2);
         id_ctrl = vecs[i].ctrl;
         #1;
         chk("tbl_id_ready", id_ready, 64'd1);
         chk("tbl_rf_rs1", rf_rs1, {59'd0, vecs[i].rs1});
         step();
         idle();
         chk("tbl_ex_valid", ex_valid, 64'd1);
         chk("tbl_ex_rs1", ex_rs1_data, vecs[i].exp1);
         chk("tbl_ex_rs2", ex_rs2_data, vecs[i].exp2);
         chk("tbl_ex_rd", ex_rd, {59'd0, vecs[i].rd});
         chk("tbl_ex_we", ex_rd_we, {63'd0, vecs[i].we});
         chk("tbl_ex_ctrl", ex_ctrl, {32'd0, vecs[i].ctrl});
         chk("tbl_busy", dut.busy_r, {32'd0, vecs[i].exp_busy});
      end

      // back-to-back independent ops
      do_reset();
      op(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 64'h11, 64'h22);
      #1 chk("b2b_ready0", id_ready, 64'd1);
      step();
      chk("b2b_ex_rs1_a", ex_rs1_data, 64'h11);
      op(5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 64'h44, 64'h55);
      #1 chk("b2b_ready1", id_ready, 64'd1);
      step();
      idle();
      chk("b2b_ex_rd_b", ex_rd, 64'd6);
      chk("b2b_ex_rs1_b", ex_rs1_data, 64'h44);
      chk("b2b_busy", dut.busy_r, 64'h48);
      step();
      chk("b2b_drain", ex_valid, 64'd0);

      // RAW with writeback bypass
      do_reset();
      op(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 64'd0, 64'd0);
      step();
      op(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 64'h1234, 64'd0);
      for (int c = 0; c < 3; c++) begin
         #1 chk("raw_stall", id_ready, 64'd0);
         step();
      end
      wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD;
      #1 chk("raw_ready_wb", id_ready, 64'd1);
      step();
      idle();
      chk("raw_ex_valid", ex_valid, 64'd1);
      chk("raw_bypass", ex_rs1_data, 64'hDEAD);
      chk("raw_busy", dut.busy_r, 64'h100);

      // WAW, then same-cycle set/clear of the same register
      do_reset();
      op(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 64'd0, 64'd0);
      step();
      op(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 64'h77, 64'd0);
      #1 chk("waw_stall", id_ready, 64'd0);
      step();
      wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h9;
      #1 chk("waw_ready_wb", id_ready, 64'd1);
      step();
      idle();
      chk("waw_issued", ex_valid, 64'd1);
      chk("waw_ex_rs1", ex_rs1_data, 64'h77);
      chk("waw_busy_kept", dut.busy_r, 64'h80);

      // backpressure
      do_reset();
      ex_ready = 1'b0;
      op(5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 64'hAAA, 64'hBBB);
      step();
      op(5'd3, 1'b1, 5'd4, 1'b1, 5'd11, 1'b1, 64'h999, 64'h888);
      for (int c = 0; c < 4; c++) begin
         rf_rs1_data = 64'h999 + 64'(c);
         #1;
         chk("bp_ready", id_ready, 64'd0);
         chk("bp_valid", ex_valid, 64'd1);
         chk("bp_rs1", ex_rs1_data, 64'hAAA);
         chk("bp_rs2", ex_rs2_data, 64'hBBB);
         chk("bp_rd", ex_rd, 64'd10);
         step();
      end
      rf_rs1_data = 64'h999;
      ex_ready = 1'b1;
      #1 chk("bp_release", id_ready, 64'd1);
      step();
      idle();
      chk("bp_next_rs1", ex_rs1_data, 64'h999);
      chk("bp_next_rd", ex_rd, 64'd11);

      // flush of a held instruction
      do_reset();
      ex_ready = 1'b0;
      op(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 64'd0, 64'd0);
      step();
      chk("fl_busy_set", dut.busy_r, 64'h200);
      op(5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 64'h5, 64'h6);
      flush = 1'b1;
      #1 chk("fl_no_ready", id_ready, 64'd0);
      step();
      idle();
      ex_ready = 1'b0;
      chk("fl_ex_valid", ex_valid, 64'd0);
      chk("fl_busy_clr", dut.busy_r, 64'd0);
      step();
      chk("fl_no_issue", ex_valid, 64'd0);

      // x0 destination and source with a writeback to x0
      do_reset();
      op(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 64'd0, 64'd0);
      wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
      #1 chk("x0_ready", id_ready, 64'd1);
      step();
      idle();
      chk("x0_ex_rs1", ex_rs1_data, 64'd0);
      chk("x0_busy", dut.busy_r, 64'd0);

      // reset during a stalled handshake
      ex_ready = 1'b0;
      op(5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 64'h3, 64'h4);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      chk("rst_mid_valid", ex_valid, 64'd0);
      chk("rst_mid_busy", dut.busy_r, 64'd0);
      chk("rst_mid_rs1", ex_rs1_data, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage between decode and execute.
- Drives the integer register file read ports and bypasses writeback data over the same-cycle register file write.
- Keeps a per-register busy scoreboard for in-flight writes and stalls on RAW/WAW hazards.
- Holds a single output register to execute with a valid/ready handshake.

Parameters:
XLEN, 64, operand/result data width
CTRL_W, 32, width of opaque decode control payload passed to execute

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  kill held instruction and block issue this cycle
id_valid  input  1  decode offers an instruction
id_ready  output  1  instruction accepted this cycle
id_rs1  input  5  source 1 index
id_rs2  input  5  source 2 index
id_rs1_used  input  1  rs1 is read
id_rs2_used  input  1  rs2 is read
id_rd  input  5  destination index
id_rd_we  input  1  instruction writes rd
id_ctrl  input  CTRL_W  payload to execute
rf_rs1  output  5  register file read index 1 (= id_rs1)
rf_rs2  output  5  register file read index 2 (= id_rs2)
rf_rs1_data  input  XLEN  combinational read data 1 (x0 reads 0)
rf_rs2_data  input  XLEN  combinational read data 2
wb_valid  input  1  writeback this cycle (same strobe as register file we)
wb_rd  input  5  writeback index
wb_data  input  XLEN  writeback data
ex_valid  output  1  output register holds an instruction
ex_ready  input  1  execute accepts
ex_rs1_data  output  XLEN  captured operand 1
ex_rs2_data  output  XLEN  captured operand 2
ex_rd  output  5  destination
ex_rd_we  output  1  destination write enable
ex_ctrl  output  CTRL_W  payload

Behaviour:
- Reset (rst=1 at edge): busy[31:1]=0, ex_valid=0, ex_rs1_data=ex_rs2_data=0, ex_rd=0, ex_rd_we=0, ex_ctrl=0. Reset overrides all other inputs, including mid-handshake.
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Scoreboard:
  - busy[0] is hard-wired 0 and never set.
  - busy_eff[r] = busy[r] & ~(wb_valid & wb_rd==r).
- Hazard: (id_rs1_used & busy_eff[id_rs1]) | (id_rs2_used & busy_eff[id_rs2]) | (id_rd_we & id_rd!=0 & busy_eff[id_rd]). The WAW check guarantees each busy bit has exactly one owner.
- Handshake:
  - id_ready = ~flush & ~hazard & (~ex_valid | ex_ready). Combinational; it may depend on id_valid-side fields but never on id_valid itself.
  - issue = id_valid & id_ready.
- Operand select (per source s): if wb_valid & wb_rd==s & s!=0, use wb_data; otherwise use rf data. Operands are captured at issue and held stable while ex_valid & ~ex_ready.
- Output register:
  - On issue: load all ex_* fields and set ex_valid=1 (latency 1 cycle, id to ex).
  - Otherwise, ex_valid & ex_ready clears ex_valid.
  - Otherwise, hold.
- Busy update, in priority order per bit:
  1. Set on issue with id_rd_we & id_rd!=0 for busy[id_rd].
  2. Clear on flush for busy[ex_rd] if ex_valid & ex_rd_we.
  3. Clear on wb_valid for busy[wb_rd].
- Set wins over a same-cycle writeback clear of the same index: the old owner retires and the new owner issues. This cannot coincide with a flush clear, since flush blocks issue.
- Flush:
  - ex_valid←0.
  - The held instruction's busy bit is released.
  - No issue this cycle.
  - Older instructions beyond execute are unaffected and still write back.
- A wb_valid to a non-busy register leaves the scoreboard unchanged; simulation asserts this.
- Throughput: 1 instruction/cycle when there is no hazard and execute is ready.

Test Plan:
- Reset then back-to-back independent ops (rs1=1, rs2=2, rd=3; then rs1=4, rs2=5, rd=6) with rf data 0x11/0x22, ex_ready=1 -> issue on consecutive cycles, ex_rs1_data=0x11, busy[3]=busy[6]=1.
- RAW: issue rd=5, then an op with rs1=5; wb_valid, wb_rd=5, wb_data=0xDEAD arrives 3 cycles later -> id_ready=0 for 3 cycles, issue in the wb cycle, ex_rs1_data=0xDEAD (bypass), busy[5]=0.
- WAW plus same-cycle set/clear: busy[7]=1; next op rd=7 is presented while wb_rd=7 -> issue that cycle and busy[7] remains 1.
- Backpressure: ex_ready=0 for 4 cycles while holding an op, rf data changes -> ex_* stable, id_ready=0, then ex_ready=1 releases.
- Flush with held op rd=9, ex_ready=0, id_valid=1 -> ex_valid=0 next cycle, busy[9]=0, no issue during flush cycle.
- x0: rd=0 and rs1=0 with wb_rd=0, wb_data=0xFF -> no stall, ex_rs1_data=rf value (0), busy unchanged.
